// File: rtl/tmr_output_voter_if.sv
// Bundle of the voter's data-path signals.
//   in_valid_i, replica_a_i/b_i/c_i, clear_i  : sample and control, driven by the source
//   voted_data_o, voted_valid_o, error_o,
//   unrecoverable_o, replica_faulty_o         : voted result and fault status, driven by the voter
// The voter uses the slave modport; the transmitter side (or a bench) uses master.
interface tmr_output_voter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid_i;
  logic [DATA_WIDTH-1:0] replica_a_i;
  logic [DATA_WIDTH-1:0] replica_b_i;
  logic [DATA_WIDTH-1:0] replica_c_i;
  logic                  clear_i;
  logic [DATA_WIDTH-1:0] voted_data_o;
  logic                  voted_valid_o;
  logic [2:0]            error_o;
  logic                  unrecoverable_o;
  logic [2:0]            replica_faulty_o;

  modport master (
    output in_valid_i, replica_a_i, replica_b_i, replica_c_i, clear_i,
    input  voted_data_o, voted_valid_o, error_o, unrecoverable_o, replica_faulty_o
  );

  modport slave (
    input  in_valid_i, replica_a_i, replica_b_i, replica_c_i, clear_i,
    output voted_data_o, voted_valid_o, error_o, unrecoverable_o, replica_faulty_o
  );
endinterface

// File: rtl/tmr_output_voter.sv
// Bitwise 2-of-3 majority voter over three redundant transmitter words.
// Registers the voted word plus a per-sample error vector (PMU trx_error encoding:
// one-hot = that replica disagreed, more than one bit = unrecoverable) and tracks
// persistent faults, dropping a replica from the vote after FAULT_THRESHOLD
// consecutive mismatching valid samples.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : tmr_output_voter_if.slave (replica inputs, clear, voted outputs, fault flags)
module tmr_output_voter #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned FAULT_THRESHOLD = 4,
  parameter int unsigned CNT_WIDTH       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  tmr_output_voter_if.slave       bus
);

  localparam logic [CNT_WIDTH-1:0] Thresh = CNT_WIDTH'(FAULT_THRESHOLD);

  typedef enum logic [1:0] {ModeFull, ModeDegraded, ModeFailed} mode_e;

  logic [DATA_WIDTH-1:0]  r_voted_data, w_voted_data;
  logic                   r_voted_valid;
  logic [2:0]             r_error, w_error;
  logic                   r_unrec, w_unrec;
  logic [2:0]             r_faulty, w_faulty;
  logic [2:0][CNT_WIDTH-1:0] r_cnt, w_cnt;

  logic [DATA_WIDTH-1:0]  w_a, w_b, w_c, w_maj, w_h0, w_h1, w_pick;
  logic [2:0]             w_full_err;
  logic                   w_pair_eq;
  logic [1:0]             w_nfaulty;
  mode_e                  w_mode;

  assign w_a = bus.replica_a_i;
  assign w_b = bus.replica_b_i;
  assign w_c = bus.replica_c_i;

  assign w_maj      = (w_a & w_b) | (w_b & w_c) | (w_a & w_c);
  assign w_full_err = {|(w_c ^ w_maj), |(w_b ^ w_maj), |(w_a ^ w_maj)};
  assign w_nfaulty  = {1'b0, r_faulty[0]} + {1'b0, r_faulty[1]} + {1'b0, r_faulty[2]};

  always_comb begin
    w_mode = ModeFailed;
    if (w_nfaulty == 2'd0)      w_mode = ModeFull;
    else if (w_nfaulty == 2'd1) w_mode = ModeDegraded;
  end

  // Healthy pair in degraded mode (only meaningful when r_faulty is one-hot).
  always_comb begin
    w_h0 = w_a;
    w_h1 = w_b;
    unique case (r_faulty)
      3'b001:  begin w_h0 = w_b; w_h1 = w_c; end
      3'b010:  begin w_h0 = w_a; w_h1 = w_c; end
      default: begin w_h0 = w_a; w_h1 = w_b; end
    endcase
  end
  assign w_pair_eq = (w_h0 == w_h1);

  // Failed mode: lowest-index healthy replica, A if none is healthy.
  always_comb begin
    w_pick = w_a;
    if (!r_faulty[0])      w_pick = w_a;
    else if (!r_faulty[1]) w_pick = w_b;
    else if (!r_faulty[2]) w_pick = w_c;
  end

  // Voted outputs.
  always_comb begin
    w_voted_data = r_voted_data;
    w_error      = 3'b000;
    w_unrec      = 1'b0;
    if (bus.in_valid_i) begin
      unique case (w_mode)
        ModeFull: begin
          w_voted_data = w_maj;
          w_error      = w_full_err;
          w_unrec      = (w_full_err[0] & w_full_err[1]) | (w_full_err[1] & w_full_err[2]) |
                         (w_full_err[0] & w_full_err[2]);
        end
        ModeDegraded: begin
          if (w_pair_eq) begin
            w_voted_data = w_h0;
          end else begin
            w_error = 3'b111;
            w_unrec = 1'b1;
          end
        end
        default: begin
          w_voted_data = w_pick;
          w_error      = 3'b111;
          w_unrec      = 1'b1;
        end
      endcase
    end
  end

  // Mismatch counters and sticky faulty flags; clear overrides any counting.
  always_comb begin
    w_cnt    = r_cnt;
    w_faulty = r_faulty;
    if (bus.clear_i) begin
      w_cnt    = '0;
      w_faulty = 3'b000;
    end else if (bus.in_valid_i) begin
      for (int i = 0; i < 3; i++) begin
        if (w_mode == ModeFull) begin
          if (w_full_err[i]) begin
            w_cnt[i] = (r_cnt[i] >= Thresh) ? Thresh : r_cnt[i] + CNT_WIDTH'(1);
          end else begin
            w_cnt[i] = '0;
          end
        end else if (w_mode == ModeDegraded) begin
          if (!r_faulty[i] && w_pair_eq) w_cnt[i] = '0;
        end
        if (w_cnt[i] >= Thresh) w_faulty[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_voted_data  <= '0;
      r_voted_valid <= 1'b0;
      r_error       <= 3'b000;
      r_unrec       <= 1'b0;
      r_faulty      <= 3'b000;
      r_cnt         <= '0;
    end else begin
      r_voted_data  <= w_voted_data;
      r_voted_valid <= bus.in_valid_i;
      r_error       <= w_error;
      r_unrec       <= w_unrec;
      r_faulty      <= w_faulty;
      r_cnt         <= w_cnt;
    end
  end

  assign bus.voted_data_o     = r_voted_data;
  assign bus.voted_valid_o    = r_voted_valid;
  assign bus.error_o          = r_error;
  assign bus.unrecoverable_o  = r_unrec;
  assign bus.replica_faulty_o = r_faulty;

endmodule
